// File: rtl/neuron_pkg.sv
// Shared types and helpers for the vector neuron processing element.
package neuron_pkg;

    typedef enum logic [1:0] {ACC, DRAIN, FIN, OUT} state_e;

    localparam logic ACT_LINEAR = 1'b0;
    localparam logic ACT_RELU   = 1'b1;

    // Arithmetic right shift (floor) followed by clamping to a signed dw-bit range.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value,
                                                     input int frac_bits,
                                                     input int dw);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = value >>> frac_bits;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
    endfunction

endpackage

// File: rtl/neuron_wmem.sv
// Weight store: BEATS words of LANES packed weights, filled one lane at a time.
module neuron_wmem
    import neuron_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 16,
    parameter int BEATS      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] raddr,
    output logic [LANES*DATA_WIDTH-1:0] rdata
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES*DATA_WIDTH-1:0] mem [BEATS];
    logic [BW-1:0]               wr_word;
    logic [LW-1:0]               wr_lane;

    // Contents survive reset; only the write pointer is cleared.
    always_ff @(posedge clk) begin
        if (we) mem[wr_word][wr_lane*DATA_WIDTH +: DATA_WIDTH] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_word <= '0;
            wr_lane <= '0;
        end else if (we) begin
            if (wr_lane == LW'(LANES - 1)) begin
                wr_lane <= '0;
                wr_word <= (wr_word == BW'(BEATS - 1)) ? '0 : wr_word + 1'b1;
            end else begin
                wr_lane <= wr_lane + 1'b1;
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/neuron_vec_pe.sv
// Multi-lane neuron: streamed MAC over stored weights, bias add, saturate, optional ReLU.
module neuron_vec_pe
    import neuron_pkg::*;
#(
    parameter int LAYER_NO   = 1,
    parameter int NEURON_NO  = 0,
    parameter int NUM_WEIGHT = 8,
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 14
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        weight_valid,
    input  logic                        bias_valid,
    input  logic [31:0]                 weight_value,
    input  logic [31:0]                 bias_value,
    input  logic [31:0]                 config_layer_num,
    input  logic [31:0]                 config_neuron_num,
    input  logic                        act_mode,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        cfg_err
);

    localparam int BEATS  = NUM_WEIGHT / LANES;
    localparam int ACC_W  = 2*DATA_WIDTH + $clog2(NUM_WEIGHT) + 1;
    localparam int TW     = ACC_W + 1;
    localparam int PW     = 2*DATA_WIDTH;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int STAGES = 1;

    state_e                          state, state_nxt;
    logic [BW-1:0]                   beat_cnt;
    logic                            drain_cnt;
    logic [STAGES:0]                 vld_pipe;
    logic [LANES-1:0][DATA_WIDTH-1:0] x_q, w_q;
    logic [LANES-1:0][PW-1:0]        prod, prod_q;
    logic signed [ACC_W-1:0]         acc, prod_sum;
    logic [DATA_WIDTH-1:0]           bias_reg;
    logic [LANES*DATA_WIDTH-1:0]     w_word;
    logic signed [TW-1:0]            t_fin;
    logic signed [63:0]              r_sat;
    logic [DATA_WIDTH-1:0]           res;
    logic                            accept, last_beat, cfg_hit, idle, out_fire, w_we;
    logic                            unused;

    assign accept    = in_valid & in_ready;
    assign last_beat = (beat_cnt == BW'(BEATS - 1));
    assign cfg_hit   = (config_layer_num == 32'(LAYER_NO)) && (config_neuron_num == 32'(NEURON_NO));
    assign idle      = (state == ACC) && (beat_cnt == '0) && !accept;
    assign out_fire  = out_valid & out_ready;
    assign w_we      = weight_valid & cfg_hit & idle;
    assign unused    = &{1'b0, weight_value[31:DATA_WIDTH], bias_value[31:DATA_WIDTH],
                         r_sat[63:DATA_WIDTH]};

    neuron_wmem #(
        .LANES     (LANES),
        .DATA_WIDTH(DATA_WIDTH),
        .BEATS     (BEATS)
    ) u_wmem (
        .clk  (clk),
        .rst  (rst),
        .we   (w_we),
        .wdata(weight_value[DATA_WIDTH-1:0]),
        .raddr(beat_cnt),
        .rdata(w_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ACC;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:   if (accept && last_beat) state_nxt = DRAIN;
            DRAIN: if (drain_cnt)           state_nxt = FIN;
            FIN:                            state_nxt = OUT;
            OUT:   if (out_fire)            state_nxt = ACC;
            default:                        state_nxt = ACC;
        endcase
    end

    always_comb begin
        in_ready = (state == ACC);
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign prod[i] = $signed(x_q[i]) * $signed(w_q[i]);
    end

    always_comb begin
        prod_sum = '0;
        for (int i = 0; i < LANES; i++) prod_sum = prod_sum + ACC_W'($signed(prod_q[i]));
    end

    // Bias is aligned to the accumulator's 2*FRAC_BITS scale before the single rounding shift.
    always_comb begin
        t_fin = TW'(acc) + (TW'($signed(bias_reg)) <<< FRAC_BITS);
        r_sat = sat_shift(64'(t_fin), FRAC_BITS, DATA_WIDTH);
        res   = r_sat[DATA_WIDTH-1:0];
        if (act_mode == ACT_RELU && r_sat < 0) res = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt  <= '0;
            drain_cnt <= 1'b0;
            vld_pipe  <= '0;
            x_q       <= '0;
            w_q       <= '0;
            prod_q    <= '0;
            acc       <= '0;
            bias_reg  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], accept};
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (accept) begin
                x_q      <= in_data;
                w_q      <= w_word;
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (vld_pipe[0]) prod_q <= prod;
            if (state == OUT && out_fire) acc <= '0;
            else if (vld_pipe[STAGES])    acc <= acc + prod_sum;
            if (bias_valid && cfg_hit && idle) bias_reg <= bias_value[DATA_WIDTH-1:0];
            if ((weight_valid || bias_valid) && cfg_hit && !idle) cfg_err <= 1'b1;
            if (state == FIN) begin
                out_data  <= res;
                out_valid <= 1'b1;
            end else if (state == OUT && out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neuron_vec_pe.sv
// Directed bench for neuron_vec_pe with a cycle-level behavioural scoreboard.
module tb_neuron_vec_pe;

    localparam int DW = 16;
    localparam int LANES = 2;
    localparam int NW = 4;

    logic        clk, rst;
    logic [31:0] in_data;
    logic        in_valid, in_ready;
    logic        weight_valid, bias_valid;
    logic [31:0] weight_value, bias_value, config_layer_num, config_neuron_num;
    logic        act_mode;
    logic [15:0] out_data;
    logic        out_valid, out_ready, cfg_err;

    neuron_vec_pe #(
        .LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(NW), .LANES(LANES),
        .DATA_WIDTH(DW), .FRAC_BITS(14)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .weight_valid(weight_valid), .bias_valid(bias_valid),
        .weight_value(weight_value), .bias_value(bias_value),
        .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
        .act_mode(act_mode), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model state: weights by flat index, bias, beat progress, result queue.
    logic signed [15:0] w_m [NW] = '{default: 16'sd0};
    logic [15:0] bias_m = '0;
    logic [15:0] hold_exp = '0;
    logic [15:0] exp_q [$];
    int          widx = 0, mb = 0, since = 0;
    longint      sum_m = 0;
    bit          m_err = 0, pend = 0, holding = 0;

    function automatic logic [15:0] model_out(input longint s, input logic [15:0] b, input bit relu);
        longint t, r;
        t = s + longint'($signed(b)) * 16384;
        r = t >>> 14;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return r[15:0];
    endfunction

    always @(negedge clk) begin : monitor
        bit acc_now, busy, hit, exp_ov;
        if (!rst) begin
            widx = 0; mb = 0; sum_m = 0; bias_m = '0; m_err = 0;
            pend = 0; holding = 0; since = 0; exp_q.delete();
        end else begin
            acc_now = in_valid && in_ready;
            busy    = (mb != 0) || pend || holding || acc_now;
            if (pend) since++;
            exp_ov = holding || (pend && since >= 4);
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            check("in_ready", 32'(in_ready), 32'(!(pend || holding)));
            check("cfg_err", 32'(cfg_err), 32'(m_err));
            if (pend && since >= 4) begin
                hold_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
                check("out_data model", 32'(out_data), 32'(hold_exp));
                pend    = 0;
                holding = out_valid;
            end else if (holding) begin
                check("out_data hold", 32'(out_data), 32'(hold_exp));
            end
            hit = (config_layer_num == 1) && (config_neuron_num == 0);
            if ((weight_valid || bias_valid) && hit && busy) m_err = 1;
            if (weight_valid && hit && !busy) begin
                w_m[widx] = weight_value[15:0];
                widx = (widx + 1) % NW;
            end
            if (bias_valid && hit && !busy) bias_m = bias_value[15:0];
            if (holding && out_valid && out_ready) holding = 0;
            if (acc_now) begin
                for (int l = 0; l < LANES; l++)
                    sum_m += longint'($signed(in_data[l*16 +: 16])) * longint'(w_m[mb*LANES + l]);
                mb++;
                if (mb == NW / LANES) begin
                    exp_q.push_back(model_out(sum_m, bias_m, act_mode));
                    pend = 1; since = 0; mb = 0; sum_m = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_w(input logic [15:0] v, input logic [31:0] neu);
        weight_valid = 1'b1; weight_value = {16'h0, v}; config_neuron_num = neu;
        cyc();
        weight_valid = 1'b0; config_neuron_num = 0;
    endtask

    task automatic wr_b(input logic [15:0] v);
        bias_valid = 1'b1; bias_value = {16'h0, v};
        cyc();
        bias_valid = 1'b0;
    endtask

    task automatic load4(input logic [15:0] v);
        for (int i = 0; i < 4; i++) wr_w(v, 0);
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        in_valid = 1'b1; in_data = {b, a};
        while (!in_ready && n < 50) begin cyc(); n++; end
        if (!in_ready) check("in_ready timeout", 0, 1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic vec(input logic [15:0] a0, a1, b0, b1, input bit gap);
        beat(a0, a1);
        if (gap) begin cyc(); cyc(); end
        beat(b0, b1);
    endtask

    task automatic get_out(output logic [15:0] d);
        int n = 0;
        while (!out_valid && n < 20) begin cyc(); n++; end
        if (!out_valid) check("out_valid timeout", 0, 1);
        d = out_data;
        if (out_ready) cyc();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] d;
        rst = 1'b0; in_data = '0; in_valid = 0; weight_valid = 0; bias_valid = 0;
        weight_value = '0; bias_value = '0; config_layer_num = 1; config_neuron_num = 0;
        act_mode = 0; out_ready = 1;
        cyc(); cyc();
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out_data", 32'(out_data), 0);
        check("reset cfg_err", 32'(cfg_err), 0);
        rst = 1'b1;
        cyc();
        check("reset in_ready", 32'(in_ready), 1);

        load4(16'h4000);
        wr_b(16'h1000);
        vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 0); get_out(d);
        check("basic", 32'(d), 'h5000);
        vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 1); get_out(d);
        check("gap", 32'(d), 'h5000);
        vec(16'h2000, 16'h2000, 16'h2000, 16'h2000, 0); get_out(d);
        check("saturate", 32'(d), 'h7FFF);

        load4(16'hC000);
        vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 0); get_out(d);
        check("neg linear", 32'(d), 'hD000);
        act_mode = 1;
        vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 0); get_out(d);
        check("relu", 32'(d), 'h0000);
        act_mode = 0;

        // Distinct weights per index pin the lane/word mapping.
        wr_w(16'h4000, 0); wr_w(16'h2000, 0); wr_w(16'hE000, 0); wr_w(16'h1000, 0);
        vec(16'h2000, 16'h0800, 16'h1000, 16'h1000, 0); get_out(d);
        check("lane map", 32'(d), 'h3000);

        load4(16'h4000);
        out_ready = 0;
        vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 0); get_out(d);
        check("bp value", 32'(d), 'h5000);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("bp stable", 32'(out_data), 32'(d));
            check("bp in_ready", 32'(in_ready), 0);
        end
        in_valid = 1; in_data = {16'h1000, 16'h1000}; out_ready = 1;
        cyc();
        check("bp released valid", 32'(out_valid), 0);
        check("bp next ready", 32'(in_ready), 1);
        cyc();
        in_valid = 0;
        beat(16'h1000, 16'h1000); get_out(d);
        check("bp next vector", 32'(d), 'h5000);

        wr_w(16'h7FFF, 5);
        vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 0); get_out(d);
        check("filtered write", 32'(d), 'h5000);

        vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 0);
        wr_w(16'h7FFF, 0);
        check("busy cfg_err", 32'(cfg_err), 1);
        get_out(d);
        check("busy write dropped", 32'(d), 'h5000);

        beat(16'h1000, 16'h1000);
        rst = 1'b0;
        cyc(); cyc();
        check("midreset out_valid", 32'(out_valid), 0);
        check("midreset out_data", 32'(out_data), 0);
        check("midreset cfg_err", 32'(cfg_err), 0);
        rst = 1'b1;
        cyc();
        check("midreset in_ready", 32'(in_ready), 1);
        wr_b(16'h1000);
        vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 0); get_out(d);
        check("post reset", 32'(d), 'h5000);

        load4(16'h4000);
        wr_w(16'h2000, 0);
        vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 0); get_out(d);
        check("weight wrap", 32'(d), 'h4800);

        repeat (3) cyc();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
